// File: rtl/led_scanner_pkg.sv
// Shared definitions for the LED scanner: run modes and bounce direction encodings.
package led_scanner_pkg;

  // Run-time scan modes, sampled only on a head step
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_WRAP_L = 2'b01,
    MODE_WRAP_R = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Bounce direction: up walks towards the last LED, down towards LED 0
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: holds a brightness level that is reloaded to full or halved
// on every head step, and drives the pin from a registered PWM comparison.
module led_pwm_channel #(
  parameter int PWM_BITS = 4
) (
  input  logic                clki,
  input  logic                reset,
  input  logic                tick,
  input  logic                load,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] intensity;

  // Brightness changes only on a head step: the head channel jumps to full, the rest fade by half
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      intensity <= '0;
    end else if (tick) begin
      if (load) begin
        intensity <= MAX;
      end else begin
        intensity <= intensity >> 1;
      end
    end
  end

  // Full brightness is forced solid so the head never flickers at the top of the PWM ramp
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      led <= (intensity == MAX) || (intensity > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_scanner.sv
// Larson scanner top: step prescaler, head position/direction tracking,
// shared PWM ramp and one fading channel per LED.
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int STEP_DIV = 2500000,
  parameter int PWM_BITS = 4,
  localparam int POS_W   = $clog2(NUM_LEDS)
) (
  input  logic                clki,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic [POS_W-1:0]    pos,
  output logic                dir
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic                primed;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [POS_W-1:0]    next_pos;
  logic                next_dir;
  logic [NUM_LEDS-1:0] load;

  assign tick = enable && (cnt == CNT_LAST);

  // Step prescaler: advances only while enabled and holds its count while frozen
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Free-running PWM ramp shared by every channel; keeps running while stepping is frozen
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Where the head lands on the next step; the very first step after reset only lights LED 0
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (!primed) begin
      next_pos = '0;
    end else begin
      case (mode_e'(mode))
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos == POS_LAST) begin
              next_pos = pos - POS_ONE;
              next_dir = DIR_DOWN;
            end else begin
              next_pos = pos + POS_ONE;
            end
          end else begin
            if (pos == '0) begin
              next_pos = pos + POS_ONE;
              next_dir = DIR_UP;
            end else begin
              next_pos = pos - POS_ONE;
            end
          end
        end
        MODE_WRAP_L: begin
          next_pos = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        end
        MODE_WRAP_R: begin
          next_pos = (pos == '0) ? POS_LAST : pos - POS_ONE;
        end
        default: begin
          next_pos = pos;
        end
      endcase
    end
  end

  // Head position, direction and the primed flag move together on each step
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      pos    <= '0;
      dir    <= DIR_UP;
      primed <= 1'b0;
    end else if (tick) begin
      pos    <= next_pos;
      dir    <= next_dir;
      primed <= 1'b1;
    end
  end

  // One channel per LED; the channel at the new head position is reloaded to full
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    assign load[i] = (next_pos == POS_W'(i));

    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clki   (clki),
      .reset  (reset),
      .tick   (tick),
      .load   (load[i]),
      .pwm_cnt(pwm_cnt),
      .led    (leds[i])
    );
  end

endmodule
